// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous-read memory between an
// instruction-fetch port (read-only) and a load/store port, and decodes one
// memory-mapped LED register on the load/store port.
// Each transaction takes IDLE -> ACCESS -> RESP. The ack is registered on the
// RESP edge, so it is visible in the cycle that follows RESP.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the grant on simultaneous
// requests. When it is undefined, the data port always wins ties.
module mem_bus_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch port
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [31:0]           i_rdata,
    // load/store port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_ack,
    output logic [31:0]           d_rdata,
    // shared memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    // LED register
    output logic [7:0]            leds
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Captured transaction; r_grant_d = 1 means the load/store port owns it.
    logic                r_grant_d;
    logic [MEM_AW-1:0]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_led_hit;

    logic                r_i_ack;
    logic                r_d_ack;
    logic [31:0]         r_i_rdata;
    logic [31:0]         r_d_rdata;
    logic [7:0]          r_leds;

    logic                w_any_req;
    logic                w_pick_d;
    logic                w_mem_en;
    logic                w_mem_we;
    logic [3:0]          w_mem_wstrb;

    // Low byte-offset bits and bits above the memory range are don't-care
    // on the fetch path.
    logic                w_unused;
    assign w_unused = ^i_addr;

    assign w_any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Port that won the most recent arbitration; reset value favours I next.
    logic r_last_d;

    // On a tie, grant the port that did not win last time.
    always_comb begin
        w_pick_d = d_req;
        if (i_req && d_req)
            w_pick_d = ~r_last_d;
    end

    // Remember the winner at every IDLE -> ACCESS transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_d <= 1'b1;
        else if (r_state == S_IDLE && w_any_req)
            r_last_d <= w_pick_d;
    end
`else
    // Fixed priority: data port wins every tie.
    always_comb begin
        w_pick_d = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic and memory-port strobes for the ACCESS cycle.
    always_comb begin
        w_next_state = r_state;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_wstrb  = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (w_any_req)
                    w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                w_mem_en     = ~r_led_hit;
                w_mem_we     = r_we & ~r_led_hit;
                w_mem_wstrb  = (r_we & ~r_led_hit) ? r_wstrb : 4'b0000;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture the winner and its request fields on the IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_d <= 1'b1;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= 4'b0000;
            r_led_hit <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_grant_d <= w_pick_d;
            r_addr    <= w_pick_d ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
            r_we      <= w_pick_d & d_we;
            r_wdata   <= d_wdata;
            r_wstrb   <= w_pick_d ? d_wstrb : 4'b0000;
            r_led_hit <= w_pick_d && (d_addr == LED_ADDR);
        end
    end

    // LED register write lands on the ACCESS edge; only byte lane 0 matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_leds <= 8'h00;
        else if (r_state == S_ACCESS && r_led_hit && r_we && r_wstrb[0])
            r_leds <= r_wdata[7:0];
    end

    // Register the one-cycle ack and the read data on the RESP edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= (r_state == S_RESP) & ~r_grant_d;
            r_d_ack <= (r_state == S_RESP) &  r_grant_d;
            if (r_state == S_RESP) begin
                if (r_grant_d)
                    r_d_rdata <= r_led_hit ? {24'h000000, r_leds} : mem_rdata;
                else
                    r_i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_we;
    assign mem_wstrb = w_mem_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign leds      = r_leds;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 1024-word memory.
// Expected ack order on a tie depends on ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    logic        mem_load = 1'b1;
    logic [31:0] mem [0:1023];

    int          cnt_en = 0;
    int          cnt_we = 0;
    logic [9:0]  last_addr = '0;
    logic [3:0]  last_wstrb = '0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .leds(leds)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory with byte strobes; preloaded while mem_load is high.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
            mem[0] <= 32'h0000_0013;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Activity counters on the memory port.
    always @(posedge clk) begin
        if (mem_en) begin
            cnt_en    <= cnt_en + 1;
            last_addr <= mem_addr;
            if (mem_we) begin
                cnt_we     <= cnt_we + 1;
                last_wstrb <= mem_wstrb;
            end
        end
    end

    // One request on one port; returns ack latency (0 = timed out), read data,
    // whether the other port acked, and ack level one cycle after the ack.
    task automatic run_access(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              output int lat, output logic [31:0] rd,
                              output bit other_ack, output logic ack_after);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = 0; rd = '0; other_ack = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (is_d ? i_ack : d_ack) other_ack = 1'b1;
            if (is_d ? d_ack : i_ack) begin
                lat = c;
                rd  = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        ack_after = is_d ? d_ack : i_ack;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (i_ack !== 1'b0)   begin errors++; $display("FAIL reset_i_ack got %b want 0", i_ack); end
        checks++; if (d_ack !== 1'b0)   begin errors++; $display("FAIL reset_d_ack got %b want 0", d_ack); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0)
            begin errors++; $display("FAIL reset_mem got en=%b we=%b wstrb=%h want 0/0/0", mem_en, mem_we, mem_wstrb); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
            begin errors++; $display("FAIL reset_rdata got i=%h d=%h want 0/0", i_rdata, d_rdata); end
        checks++; if (leds !== 8'h00)   begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
        @(negedge clk);
        rst = 1'b0; mem_load = 1'b0;
    endtask

    task automatic test_ifetch;
        int lat; logic [31:0] rd; bit oth; logic aft; int we0;
        we0 = cnt_we;
        run_access(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (lat !== 3)             begin errors++; $display("FAIL ifetch_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h0000_0013)  begin errors++; $display("FAIL ifetch_rdata got %h want 00000013", rd); end
        checks++; if (cnt_we !== we0)        begin errors++; $display("FAIL ifetch_no_write got %0d writes want 0", cnt_we - we0); end
        checks++; if (oth !== 1'b0)          begin errors++; $display("FAIL ifetch_d_ack got 1 want 0"); end
        checks++; if (aft !== 1'b0)          begin errors++; $display("FAIL ifetch_ack_pulse got %b want 0", aft); end
    endtask

    task automatic test_dmem;
        int lat; logic [31:0] rd; bit oth; logic aft; int we0;
        we0 = cnt_we;
        run_access(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, oth, aft);
        checks++; if (lat !== 3)             begin errors++; $display("FAIL dwr_latency got %0d want 3", lat); end
        checks++; if (last_addr !== 10'd4)   begin errors++; $display("FAIL dwr_mem_addr got %0d want 4", last_addr); end
        checks++; if (cnt_we !== we0 + 1 || last_wstrb !== 4'hF)
            begin errors++; $display("FAIL dwr_strobe got writes=%0d wstrb=%h want 1/f", cnt_we - we0, last_wstrb); end
        checks++; if (oth !== 1'b0 || aft !== 1'b0)
            begin errors++; $display("FAIL dwr_ack_shape got other=%b after=%b want 0/0", oth, aft); end
        we0 = cnt_we;
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (rd !== 32'hDEAD_BEEF)  begin errors++; $display("FAIL drd_rdata got %h want deadbeef", rd); end
        checks++; if (last_addr !== 10'd4 || cnt_we !== we0)
            begin errors++; $display("FAIL drd_mem got addr=%0d writes=%0d want 4/0", last_addr, cnt_we - we0); end
        // byte-lane write, then read through an unaligned address of the same word
        run_access(1'b1, 1'b1, 32'h10, 32'h1122_3344, 4'b0001, lat, rd, oth, aft);
        checks++; if (last_wstrb !== 4'b0001) begin errors++; $display("FAIL dwr_partial_wstrb got %h want 1", last_wstrb); end
        run_access(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (rd !== 32'hDEAD_BE44)  begin errors++; $display("FAIL drd_partial got %h want deadbe44", rd); end
    endtask

    task automatic test_led;
        int lat; logic [31:0] rd; bit oth; logic aft; int en0;
        en0 = cnt_en;
        run_access(1'b1, 1'b1, 32'h1000, 32'h0000_00A5, 4'hF, lat, rd, oth, aft);
        checks++; if (lat !== 3)             begin errors++; $display("FAIL ledwr_latency got %0d want 3", lat); end
        checks++; if (leds !== 8'hA5)        begin errors++; $display("FAIL ledwr_value got %h want a5", leds); end
        run_access(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (rd !== 32'h0000_00A5)  begin errors++; $display("FAIL ledrd_rdata got %h want 000000a5", rd); end
        checks++; if (cnt_en !== en0)        begin errors++; $display("FAIL led_no_mem_en got %0d enables want 0", cnt_en - en0); end
        run_access(1'b1, 1'b1, 32'h1000, 32'h0000_005A, 4'b1110, lat, rd, oth, aft);
        checks++; if (leds !== 8'hA5)        begin errors++; $display("FAIL ledwr_lane0_off got %h want a5", leds); end
        // fetch port has no LED decode: 0x1000 aliases memory word 0
        en0 = cnt_en;
        run_access(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (rd !== 32'h0000_0013 || cnt_en !== en0 + 1 || last_addr !== 10'd0)
            begin errors++; $display("FAIL ifetch_led_addr got rd=%h en=%0d addr=%0d want 00000013/1/0", rd, cnt_en - en0, last_addr); end
    endtask

    task automatic test_tie;
        logic [7:0] seq [0:3];
        logic [7:0] exp [0:3];
        int n; bit both;
`ifdef ARB_ROUND_ROBIN_EN
        exp[0] = "I"; exp[1] = "D"; exp[2] = "I"; exp[3] = "D";
`else
        exp[0] = "D"; exp[1] = "D"; exp[2] = "D"; exp[3] = "D";
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n = 0; both = 1'b0;
        for (int k = 0; k < 4; k++) seq[k] = "-";
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) both = 1'b1;
            if (i_ack || d_ack) begin
                if (n < 4) seq[n] = i_ack ? "I" : "D";
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);
        checks++; if (n !== 4)      begin errors++; $display("FAIL tie_ack_count got %0d want 4", n); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL tie_double_ack got 1 want 0"); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seq[k] !== exp[k]) begin errors++; $display("FAIL tie_order[%0d] got %s want %s", k, seq[k], exp[k]); end
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rd; bit oth; logic aft; int we0; bit acked;
        we0 = cnt_we;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        @(posedge clk); #2;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL abort_in_access got mem_en=%b want 1", mem_en); end
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0)
            begin errors++; $display("FAIL abort_async got en=%b we=%b want 0/0", mem_en, mem_we); end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        acked = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (d_ack || i_ack) acked = 1'b1; end
        checks++; if (acked !== 1'b0)  begin errors++; $display("FAIL abort_no_ack got ack want none"); end
        checks++; if (mem[8] !== 32'h0 || cnt_we !== we0)
            begin errors++; $display("FAIL abort_no_write got word8=%h writes=%0d want 0/0", mem[8], cnt_we - we0); end
        checks++; if (leds !== 8'h00)  begin errors++; $display("FAIL abort_leds got %h want 00", leds); end
        run_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, oth, aft);
        checks++; if (lat !== 3 || rd !== 32'h0)
            begin errors++; $display("FAIL abort_idle_after got lat=%0d rd=%h want 3/0", lat, rd); end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_dmem();
        test_led();
        test_tie();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
